// File: rtl/ysyx_23060221_lsu.sv
// ============================================================================
// Module   : ysyx_23060221_lsu
// Brief    : Load/store unit. It takes one request per transaction from the
//            execute stage, runs a req/gnt/rvalid memory handshake and hands
//            the result to writeback. The optional build macro
//            LSU_MISALIGN_CHK_EN enables the misaligned-access check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060221_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXU_valid,
    output logic        LSU_ready,
    input  logic [31:0] res,
    input  logic [31:0] wdata,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic        memtoreg,
    input  logic        regw,
    output logic        LSU_valid,
    input  logic        WBU_ready,
    output logic [31:0] res_o,
    output logic [31:0] dataout,
    output logic        memtoreg_o,
    output logic        regw_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] res_q, res_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        rd_q, rd_d;
    logic        we_q, we_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regw_q, regw_d;
    logic        misalign_q, misalign_d;

    logic [1:0]  w_a;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;
    logic [3:0]  w_mask;
    logic        w_in_misaligned;

    assign w_a       = res_q[1:0];
    assign w_shifted = mem_rdata >> {w_a, 3'b000};

    always_comb begin
        w_load_ext = w_shifted;
        case (funct3_q)
            3'b000:  w_load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    // The 4-bit shift drops any lane that would fall beyond byte 3.
    always_comb begin
        w_mask = 4'b1111;
        case (funct3_q)
            3'b000:  w_mask = 4'b0001 << w_a;
            3'b001:  w_mask = 4'b0011 << w_a;
            default: w_mask = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGN_CHK_EN
    assign w_in_misaligned = (((funct3 == 3'b001) || (funct3 == 3'b101)) && res[0])
                           || ((funct3 == 3'b010) && (res[1:0] != 2'b00));
`else
    assign w_in_misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        funct3_d   = funct3_q;
        rd_d       = rd_q;
        we_d       = we_q;
        memtoreg_d = memtoreg_q;
        regw_d     = regw_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                if (EXU_valid) begin
                    res_d      = res;
                    wdata_d    = wdata;
                    data_d     = 32'd0;
                    funct3_d   = funct3;
                    rd_d       = memread;
                    // A simultaneous read and write request is a load.
                    we_d       = memwrite & ~memread;
                    memtoreg_d = memtoreg;
                    regw_d     = regw;
                    misalign_d = 1'b0;
                    if (memread | memwrite) begin
                        if (w_in_misaligned) begin
                            misalign_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            state_d    = REQ;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (rd_q) begin
                        data_d = w_load_ext;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (WBU_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            res_q      <= 32'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            funct3_q   <= 3'd0;
            rd_q       <= 1'b0;
            we_q       <= 1'b0;
            memtoreg_q <= 1'b0;
            regw_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            funct3_q   <= funct3_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            memtoreg_q <= memtoreg_d;
            regw_q     <= regw_d;
            misalign_q <= misalign_d;
        end
    end

    assign LSU_ready  = (state_q == IDLE);
    assign LSU_valid  = (state_q == DONE);
    assign res_o      = res_q;
    assign dataout    = data_q;
    assign memtoreg_o = memtoreg_q;
    assign regw_o     = regw_q & ~misalign_q;
    assign misalign   = misalign_q & (state_q == DONE);

    // Memory-side outputs are driven only while the request is outstanding.
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {res_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_we ? (wdata_q << {w_a, 3'b000}) : 32'd0;
    assign mem_wmask = mem_we ? w_mask : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060221_lsu.sv
// ============================================================================
// Module   : tb_ysyx_23060221_lsu
// Brief    : Directed self-checking bench for ysyx_23060221_lsu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060221_lsu;

    logic        clk;
    logic        rst;
    logic        EXU_valid;
    logic        LSU_ready;
    logic [31:0] res;
    logic [31:0] wdata;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic        memtoreg;
    logic        regw;
    logic        LSU_valid;
    logic        WBU_ready;
    logic [31:0] res_o;
    logic [31:0] dataout;
    logic        memtoreg_o;
    logic        regw_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060221_lsu dut (
        .clk(clk), .rst(rst), .EXU_valid(EXU_valid), .LSU_ready(LSU_ready),
        .res(res), .wdata(wdata), .memread(memread), .memwrite(memwrite),
        .funct3(funct3), .memtoreg(memtoreg), .regw(regw), .LSU_valid(LSU_valid),
        .WBU_ready(WBU_ready), .res_o(res_o), .dataout(dataout),
        .memtoreg_o(memtoreg_o), .regw_o(regw_o), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        EXU_valid = 1'b1; memread = rd; memwrite = wr; funct3 = f3;
        res = addr; wdata = wd; memtoreg = rd; regw = 1'b1;
    endtask

    // Runs a load with gnt at N+1 and rvalid at N+2; returns what DONE shows.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, output logic [31:0] dout,
                           output logic vld);
        issue(1'b1, 1'b0, f3, addr, 32'd0);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        step;
        mem_rvalid = 1'b0;
        dout = dataout; vld = LSU_valid;
        step;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (LSU_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", LSU_ready); end
        n_checks++; if ({LSU_valid, mem_req, mem_we, misalign, memtoreg_o, regw_o} !== 6'd0) begin n_fail++; $display("FAIL reset_bits got %b exp 000000", {LSU_valid, mem_req, mem_we, misalign, memtoreg_o, regw_o}); end
        n_checks++; if ({res_o, dataout, mem_addr, mem_wdata, mem_wmask} !== 132'd0) begin n_fail++; $display("FAIL reset_buses got %h exp 0", {res_o, dataout, mem_addr, mem_wdata, mem_wmask}); end
        step;
        rst = 1'b1;
        step;
        n_checks++; if (LSU_ready !== 1'b1 || LSU_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got ready=%b valid=%b exp 1/0", LSU_ready, LSU_valid); end
    endtask

    task automatic test_nonmem;
        issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0);
        memtoreg = 1'b0;
        step;
        EXU_valid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1) begin n_fail++; $display("FAIL nonmem_valid got %b exp 1", LSU_valid); end
        n_checks++; if (res_o !== 32'h0000_1234) begin n_fail++; $display("FAIL nonmem_res_o got %h exp 00001234", res_o); end
        n_checks++; if (regw_o !== 1'b1 || dataout !== 32'd0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL nonmem_ctrl got regw=%b data=%h req=%b exp 1/0/0", regw_o, dataout, mem_req); end
        step;
        n_checks++; if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1) begin n_fail++; $display("FAIL nonmem_one_cycle got valid=%b ready=%b exp 0/1", LSU_valid, LSU_ready); end
    endtask

    task automatic test_load_lb;
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8000_0000 || mem_wmask !== 4'd0) begin n_fail++; $display("FAIL lb_req got req=%b we=%b addr=%h mask=%b exp 1/0/80000000/0000", mem_req, mem_we, mem_addr, mem_wmask); end
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF;
        n_checks++; if (mem_req !== 1'b0 || LSU_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait got req=%b valid=%b exp 0/0", mem_req, LSU_valid); end
        step;
        mem_rvalid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1 || dataout !== 32'hFFFF_FF80 || memtoreg_o !== 1'b1) begin n_fail++; $display("FAIL lb_done got valid=%b data=%h m2r=%b exp 1/ffffff80/1", LSU_valid, dataout, memtoreg_o); end
        step;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s   [5] = '{3'b010, 3'b001, 3'b101, 3'b100, 3'b000};
        logic [31:0] addrs [5] = '{32'h10, 32'h12, 32'h12, 32'h11, 32'h11};
        logic [31:0] rds   [5] = '{32'hDEADBEEF, 32'h80010000, 32'h80010000, 32'h0000F000, 32'h00007F00};
        logic [31:0] exps  [5] = '{32'hDEADBEEF, 32'hFFFF8001, 32'h00008001, 32'h000000F0, 32'h0000007F};
        logic [31:0] dout;
        logic        vld;
        for (int i = 0; i < 5; i++) begin
            do_load(f3s[i], addrs[i], rds[i], dout, vld);
            n_checks++; if (vld !== 1'b1 || dout !== exps[i]) begin n_fail++; $display("FAIL load_ext[%0d] got valid=%b data=%h exp 1/%h", i, vld, dout, exps[i]); end
        end
    endtask

    task automatic test_store_sh;
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        n_checks++; if (mem_we !== 1'b1 || mem_wmask !== 4'b1100 || mem_wdata !== 32'hBEEF_0000 || mem_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL sh_req got we=%b mask=%b wdata=%h addr=%h exp 1/1100/beef0000/80000000", mem_we, mem_wmask, mem_wdata, mem_addr); end
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step;
        mem_rvalid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1 || dataout !== 32'd0) begin n_fail++; $display("FAIL sh_done got valid=%b data=%h exp 1/0", LSU_valid, dataout); end
        step;
    endtask

    task automatic test_read_write_both;
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wmask !== 4'd0) begin n_fail++; $display("FAIL rw_as_load got req=%b we=%b mask=%b exp 1/0/0000", mem_req, mem_we, mem_wmask); end
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step;
        mem_rvalid = 1'b0;
        n_checks++; if (dataout !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rw_data got %h exp cafef00d", dataout); end
        step;
    endtask

    task automatic test_stall;
        issue(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB);
        mem_gnt = 1'b0;
        step;
        EXU_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wdata !== 32'h0000_AB00 || mem_wmask !== 4'b0010 || LSU_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got req=%b we=%b addr=%h wdata=%h mask=%b ready=%b exp 1/1/80000000/0000ab00/0010/0", i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, LSU_ready); end
            step;
        end
        mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; WBU_ready = 1'b0;
        step;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (LSU_valid !== 1'b1 || LSU_ready !== 1'b0 || res_o !== 32'h8000_0001 || regw_o !== 1'b1) begin n_fail++; $display("FAIL stall_done[%0d] got valid=%b ready=%b res_o=%h regw=%b exp 1/0/80000001/1", i, LSU_valid, LSU_ready, res_o, regw_o); end
            step;
        end
        WBU_ready = 1'b1;
        step;
        n_checks++; if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got valid=%b ready=%b exp 0/1", LSU_valid, LSU_ready); end
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 1'b0, 3'b000, 32'h0000_00A1, 32'd0);
        step;
        res = 32'h0000_00B2;
        n_checks++; if (LSU_valid !== 1'b1 || res_o !== 32'h0000_00A1) begin n_fail++; $display("FAIL b2b_first got valid=%b res_o=%h exp 1/000000a1", LSU_valid, res_o); end
        step;
        n_checks++; if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1 || res_o !== 32'h0000_00A1) begin n_fail++; $display("FAIL b2b_gap got valid=%b ready=%b res_o=%h exp 0/1/000000a1", LSU_valid, LSU_ready, res_o); end
        step;
        EXU_valid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1 || res_o !== 32'h0000_00B2) begin n_fail++; $display("FAIL b2b_second got valid=%b res_o=%h exp 1/000000b2", LSU_valid, res_o); end
        step;
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        step;
        mem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (LSU_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_async got ready=%b req=%b exp 1/0", LSU_ready, mem_req); end
        step;
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (LSU_valid !== 1'b0 || LSU_ready !== 1'b1 || dataout !== 32'd0) begin n_fail++; $display("FAIL rst_drop[%0d] got valid=%b ready=%b data=%h exp 0/1/0", i, LSU_valid, LSU_ready, dataout); end
            step;
        end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_CHK_EN
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0);
        step;
        EXU_valid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1 || mem_req !== 1'b0 || misalign !== 1'b1 || regw_o !== 1'b0 || dataout !== 32'd0) begin n_fail++; $display("FAIL misalign_chk got valid=%b req=%b mis=%b regw=%b data=%h exp 1/0/1/0/0", LSU_valid, mem_req, misalign, regw_o, dataout); end
        step;
        n_checks++; if (misalign !== 1'b0 || LSU_ready !== 1'b1) begin n_fail++; $display("FAIL misalign_clear got mis=%b ready=%b exp 0/1", misalign, LSU_ready); end
`else
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0001, 32'h1122_3344);
        step;
        EXU_valid = 1'b0; mem_gnt = 1'b1;
        n_checks++; if (mem_req !== 1'b1 || misalign !== 1'b0 || mem_wdata !== 32'h2233_4400 || mem_wmask !== 4'b1111) begin n_fail++; $display("FAIL misalign_issue got req=%b mis=%b wdata=%h mask=%b exp 1/0/22334400/1111", mem_req, misalign, mem_wdata, mem_wmask); end
        step;
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        step;
        mem_rvalid = 1'b0;
        n_checks++; if (LSU_valid !== 1'b1 || misalign !== 1'b0 || regw_o !== 1'b1) begin n_fail++; $display("FAIL misalign_done got valid=%b mis=%b regw=%b exp 1/0/1", LSU_valid, misalign, regw_o); end
        step;
`endif
    endtask

    initial begin
        rst = 1'b0; EXU_valid = 1'b0; res = 32'd0; wdata = 32'd0;
        memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0; memtoreg = 1'b0;
        regw = 1'b0; WBU_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        test_reset;
        test_nonmem;
        test_load_lb;
        test_load_ext;
        test_store_sh;
        test_read_write_both;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_misalign;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
